ahb_lite_des_slave_bank: RTL

// - Parametrised AHB-Lite slave between the system bus and the Triple DES core.
// - Holds a control register, NUM_KEYS key registers, a data-in register and a buffered result register.
// - Launches the core on a data write and stalls result reads with wait states until the core finishes.
// - Reports illegal accesses with the two-cycle AHB ERROR response.

---
 rtl/ahb_lite_des_slave_bank_if.sv | 29 ++
 rtl/ahb_lite_des_slave_bank.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_des_slave_bank_if.sv
// AHB-Lite bus bundle between the system bus and the Triple DES register bank.
// Ports (signals):
//   HSEL, HADDR[31:0], HTRANS[1:0], HWRITE, HSIZE[2:0], HWDATA, HREADY  master -> slave
//   HREADYOUT, HRESP, HRDATA                                           slave  -> master
// Modports: master, slave.
interface ahb_lite_des_slave_bank_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  HSEL;
  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic [DATA_WIDTH-1:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_lite_des_slave_bank.sv
// AHB-Lite slave register bank in front of the Triple DES core.
// Holds CTRL, NUM_KEYS key registers, DATA and a buffered RESULT; launches the
// core on a DATA write, stalls RESULT reads until the core finishes and
// answers illegal accesses with the two-cycle ERROR response.
// Ports:
//   HCLK, HRESET       clock, synchronous active-high reset
//   bus (slave)        AHB-Lite signals, see ahb_lite_des_slave_bank_if
//   start              one-cycle core launch pulse
//   encryptionType     CTRL[0]
//   data, keys         data-in register, key k at keys[k*W +: W]
//   core_busy, result_valid, result_data   core status and result strobe
// Build option: define AHB_DES_KEY_READBACK_EN to make KEY registers readable.
//
// state | meaning
// IDLE  | ready for transfers, zero-wait OKAY data phases
// WAIT  | RESULT read stalled until result_valid or timeout
// ERR1  | first ERROR cycle (HREADYOUT=0, HRESP=1)
// ERR2  | second ERROR cycle (HREADYOUT=1, HRESP=1)
module ahb_lite_des_slave_bank #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_KEYS   = 3,
  parameter int REG_STRIDE = 'h400,
  parameter int WAIT_MAX   = 16
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  ahb_lite_des_slave_bank_if.slave       bus,
  output logic                           start,
  output logic                           encryptionType,
  output logic [DATA_WIDTH-1:0]          data,
  output logic [NUM_KEYS*DATA_WIDTH-1:0] keys,
  input  logic                           core_busy,
  input  logic                           result_valid,
  input  logic [DATA_WIDTH-1:0]          result_data
);
  localparam int W     = DATA_WIDTH;
  localparam int IW    = 4;
  localparam int CW    = $clog2(WAIT_MAX + 1);
  localparam int SHIFT = $clog2(REG_STRIDE);
  localparam logic [2:0]    SIZE_OK  = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [IW-1:0] IDX_CTRL = '0;
  localparam logic [IW-1:0] IDX_DATA = IW'(NUM_KEYS + 1);
  localparam logic [IW-1:0] IDX_RES  = IW'(NUM_KEYS + 2);
  localparam logic [IW-1:0] IDX_STAT = IW'(NUM_KEYS + 3);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      dp_valid_q, dp_valid_d;
  logic                      dp_write_q, dp_write_d;
  logic [IW-1:0]             dp_idx_q, dp_idx_d;
  logic [W-1:0]              ctrl_q, ctrl_d;
  logic [NUM_KEYS*W-1:0]     keys_q, keys_d;
  logic [W-1:0]              data_q, data_d;
  logic [W-1:0]              buf_q, buf_d;
  logic                      ready_q, ready_d;
  logic                      ovf_q, ovf_d;
  logic                      start_q, start_d;

  logic                      hready_out, hresp;
  logic [W-1:0]              hrdata;
  logic [31:0]               idx_full;
  logic [IW-1:0]             ap_idx;
  logic                      ap_ok, illegal, go_wait;
  state_t                    acc_state;
  logic                      wr, rd, res_rd_done, stat_rd_done;

  // Address-phase decode
  always_comb begin
    idx_full  = bus.HADDR >> SHIFT;
    ap_idx    = idx_full[IW-1:0];
    ap_ok     = bus.HSEL & bus.HREADY & bus.HTRANS[1] & hready_out;
    illegal   = (idx_full > 32'(NUM_KEYS + 3))
              | (bus.HSIZE != SIZE_OK)
              | (bus.HWRITE & ((ap_idx == IDX_RES) | (ap_idx == IDX_STAT)))
              | (bus.HWRITE & (ap_idx == IDX_DATA) & core_busy);
    // A result arriving during the address phase is buffered in time for the data phase.
    go_wait   = ~bus.HWRITE & (ap_idx == IDX_RES) & ~(ready_q | result_valid) & core_busy;
    acc_state = illegal ? ST_ERR1 : (go_wait ? ST_WAIT : ST_IDLE);
    dp_valid_d = ap_ok & ~illegal & ~go_wait;
    dp_write_d = bus.HWRITE;
    dp_idx_d   = ap_idx;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      ST_IDLE, ST_ERR2: state_d = ap_ok ? acc_state : ST_IDLE;
      ST_WAIT: begin
        if (result_valid) begin
          state_d = ap_ok ? acc_state : ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(WAIT_MAX)) state_d = ST_ERR1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
    endcase
  end

  // Register-file and result-buffer updates
  always_comb begin
    wr           = dp_valid_q & dp_write_q;
    rd           = dp_valid_q & ~dp_write_q;
    res_rd_done  = (rd & (dp_idx_q == IDX_RES)) | ((state_q == ST_WAIT) & result_valid);
    stat_rd_done = rd & (dp_idx_q == IDX_STAT);
    ctrl_d  = (wr && dp_idx_q == IDX_CTRL) ? bus.HWDATA : ctrl_q;
    data_d  = (wr && dp_idx_q == IDX_DATA) ? bus.HWDATA : data_q;
    start_d = wr && (dp_idx_q == IDX_DATA);
    keys_d  = keys_q;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (wr && dp_idx_q == IW'(k + 1)) keys_d[k*W +: W] = bus.HWDATA;
    end
    buf_d   = result_valid ? result_data : buf_q;
    ready_d = (ready_q | result_valid) & ~res_rd_done;
    // Overflow event beats a clearing STATUS read in the same cycle.
    ovf_d   = (ovf_q & ~stat_rd_done) | (result_valid & ready_q);
  end

  // Outputs
  always_comb begin
    hready_out = ~(((state_q == ST_WAIT) & ~result_valid) | (state_q == ST_ERR1));
    hresp      = (state_q == ST_ERR1) | (state_q == ST_ERR2);
    hrdata     = '0;
    if ((state_q == ST_WAIT) && result_valid) begin
      hrdata = result_data;
    end else if (rd) begin
      if (dp_idx_q == IDX_CTRL)      hrdata = ctrl_q;
      else if (dp_idx_q == IDX_DATA) hrdata = data_q;
      else if (dp_idx_q == IDX_RES)  hrdata = result_valid ? result_data : (ready_q ? buf_q : '0);
      else if (dp_idx_q == IDX_STAT) hrdata = {{(W-3){1'b0}}, ovf_q, ready_q, core_busy};
      else begin
`ifdef AHB_DES_KEY_READBACK_EN
        for (int k = 0; k < NUM_KEYS; k++) begin
          if (dp_idx_q == IW'(k + 1)) hrdata = keys_q[k*W +: W];
        end
`else
        hrdata = '0;
`endif
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_idx_q   <= '0;
      ctrl_q     <= '0;
      keys_q     <= '0;
      data_q     <= '0;
      buf_q      <= '0;
      ready_q    <= 1'b0;
      ovf_q      <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_idx_q   <= dp_idx_d;
      ctrl_q     <= ctrl_d;
      keys_q     <= keys_d;
      data_q     <= data_d;
      buf_q      <= buf_d;
      ready_q    <= ready_d;
      ovf_q      <= ovf_d;
      start_q    <= start_d;
    end
  end

  assign bus.HREADYOUT  = hready_out;
  assign bus.HRESP      = hresp;
  assign bus.HRDATA     = hrdata;
  assign start          = start_q;
  assign encryptionType = ctrl_q[0];
  assign data           = data_q;
  assign keys           = keys_q;
endmodule
